// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   - FSM state encoding (3-bit constants, legacy-compatible localparams)
//   - NOP_WORD: value served on the fetch port whenever the CPU must not
//     see real program contents (sll $0,$0,0)
//   - IM_DEPTH_DEF: default number of stored instruction words
package im_loader_pkg;

  localparam int IM_DEPTH_DEF = 1024;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef logic [2:0] state_t;

  localparam state_t ST_LOAD  = 3'd0;
  localparam state_t ST_CSUM  = 3'd1;
  localparam state_t ST_CLEAR = 3'd2;
  localparam state_t ST_RUN   = 3'd3;
  localparam state_t ST_ERR   = 3'd4;

endpackage

// File: rtl/im_array.sv
// Instruction word storage: im_depth x data_size, no reset.
// Ports:
//   clk          write clock
//   we/waddr/wdata  synchronous write port (lands at rising edge)
//   raddr/rdata     combinational read port (returns pre-edge contents)
module im_array #(
  parameter int data_size = 32,
  parameter int im_depth  = 1024,
  parameter int idx_w     = $clog2(im_depth)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [idx_w-1:0]     waddr,
  input  logic [data_size-1:0] wdata,
  input  logic [idx_w-1:0]     raddr,
  output logic [data_size-1:0] rdata
);

  logic [data_size-1:0] mem [im_depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/im_loader.sv
// Instruction memory with a program loader in front of the pipelined CPU.
// A program arrives over a valid/ready word stream, the unused tail is
// zero-filled, and only then is the CPU released from reset. A reload pulse
// in RUN restarts loading without a global reset.
//
// Optional feature (macro IM_CHECKSUM_EN): after the ld_last word one extra
// word is accepted and compared against the mod-2^data_size sum of the image;
// a mismatch is a load error.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   IM_Address          CPU fetch word address
//   Instruction         fetched word (combinational; NOP unless running)
//   ld_valid/ld_ready   load stream handshake
//   ld_data, ld_last    load word and end-of-image marker
//   reload              restart loading (only acted on while running)
//   cpu_rst             active-low reset to the CPU (high one cycle after RUN)
//   busy                high while loading, checking or clearing
//   error               sticky overflow / checksum error
//   loaded_words        words accepted in the current load
module im_loader
  import im_loader_pkg::*;
#(
  parameter int data_size = 32,
  parameter int mem_size  = 16,
  parameter int im_depth  = IM_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [mem_size-1:0]       IM_Address,
  output logic [data_size-1:0]      Instruction,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [data_size-1:0]      ld_data,
  input  logic                      ld_last,
  input  logic                      reload,
  output logic                      cpu_rst,
  output logic                      busy,
  output logic                      error,
  output logic [$clog2(im_depth):0] loaded_words
);

  localparam int idx_w = $clog2(im_depth);
  // One extra bit so the range test also works when im_depth == 2**mem_size.
  localparam logic [mem_size:0] depth_ext = (mem_size + 1)'(im_depth);

  state_t               state;
  state_t               state_nx;
  logic [idx_w-1:0]     wr_ptr;
  logic                 hs;
  logic                 last_slot;
  logic                 we;
  logic [idx_w-1:0]     waddr;
  logic [data_size-1:0] wdata;
  logic [data_size-1:0] rdata;

`ifdef IM_CHECKSUM_EN
  logic [data_size-1:0] sum;
  assign ld_ready = rst && ((state == ST_LOAD) || (state == ST_CSUM));
`else
  assign ld_ready = rst && (state == ST_LOAD);
`endif

  assign hs        = ld_valid && ld_ready;
  assign last_slot = (wr_ptr == idx_w'(im_depth - 1));
  assign busy      = (state != ST_RUN) && (state != ST_ERR);

  always_comb begin
    state_nx = state;
    case (state)
      ST_LOAD: begin
        if (hs) begin
          if (ld_last) begin
`ifdef IM_CHECKSUM_EN
            state_nx = ST_CSUM;
`else
            state_nx = ST_CLEAR;
`endif
          end else if (last_slot) begin
            state_nx = ST_ERR;
          end
        end
      end
`ifdef IM_CHECKSUM_EN
      ST_CSUM: begin
        if (hs) state_nx = (ld_data == sum) ? ST_CLEAR : ST_ERR;
      end
`endif
      // wr_ptr == 0 here only after a full image wrapped the pointer:
      // nothing left to clear.
      ST_CLEAR: begin
        if ((wr_ptr == '0) || last_slot) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (reload) state_nx = ST_LOAD;
      end
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_LOAD;
      wr_ptr       <= '0;
      loaded_words <= '0;
      error        <= 1'b0;
      cpu_rst      <= 1'b0;
`ifdef IM_CHECKSUM_EN
      sum          <= '0;
`endif
    end else begin
      state   <= state_nx;
      cpu_rst <= (state == ST_RUN);
      case (state)
        ST_LOAD: begin
          if (hs) begin
            wr_ptr       <= wr_ptr + 1'b1;
            loaded_words <= loaded_words + 1'b1;
`ifdef IM_CHECKSUM_EN
            sum          <= sum + ld_data;
`endif
            if (!ld_last && last_slot) error <= 1'b1;
          end
        end
`ifdef IM_CHECKSUM_EN
        ST_CSUM: begin
          if (hs && (ld_data != sum)) error <= 1'b1;
        end
`endif
        ST_CLEAR: begin
          if (wr_ptr != '0) wr_ptr <= wr_ptr + 1'b1;
        end
        ST_RUN: begin
          if (reload) begin
            wr_ptr       <= '0;
            loaded_words <= '0;
            error        <= 1'b0;
`ifdef IM_CHECKSUM_EN
            sum          <= '0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Single write port shared by program load and tail clear.
  always_comb begin
    we    = 1'b0;
    waddr = wr_ptr;
    wdata = ld_data;
    if ((state == ST_LOAD) && hs) begin
      we = 1'b1;
    end else if ((state == ST_CLEAR) && (wr_ptr != '0)) begin
      we    = 1'b1;
      wdata = '0;
    end
  end

  im_array #(
    .data_size (data_size),
    .im_depth  (im_depth),
    .idx_w     (idx_w)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (IM_Address[idx_w-1:0]),
    .rdata (rdata)
  );

  assign Instruction = ((state == ST_RUN) && ({1'b0, IM_Address} < depth_ext))
                       ? rdata : data_size'(NOP_WORD);

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: table-driven fetch checks, hand-written
// multi-cycle sequences (overflow, exact fill, reload, mid-load reset,
// optional checksum) and randomized images compared to a reference image.
module tb_im_loader;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] IM_Address;
  logic [31:0] Instruction;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        reload;
  logic        cpu_rst;
  logic        busy;
  logic        error;
  logic [10:0] loaded_words;

  int vectors = 0;
  int miscompares = 0;

  // Reference image: the words of the current program in load order.
  logic [31:0] img[$];

  typedef struct {
    logic [15:0] addr;
    logic [31:0] exp;
  } rd_vec_t;

  always #5 clk = ~clk;

  im_loader #(.data_size(32), .mem_size(16), .im_depth(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .IM_Address   (IM_Address),
    .Instruction  (Instruction),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .reload       (reload),
    .cpu_rst      (cpu_rst),
    .busy         (busy),
    .error        (error),
    .loaded_words (loaded_words)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Expected fetch result while running: image word, or zero past the image.
  function automatic logic [31:0] ref_word(input int addr);
    if (addr < img.size()) return img[addr];
    return 32'h0;
  endfunction

  function automatic int exp_clear(input int n);
    return (n >= DEPTH) ? 1 : DEPTH - n;
  endfunction

  task automatic rd(input logic [15:0] a, input logic [31:0] e, input string nm);
    @(negedge clk);
    IM_Address = a;
    #1;
    chk(nm, 64'(Instruction), 64'(e));
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    int n;
    n = 0;
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    #1;
    while (ld_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (ld_ready !== 1'b1) chk("ld_ready_wait", 64'(ld_ready), 64'd1);
    else begin
      @(posedge clk); #1;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic load_image(input bit gaps);
`ifdef IM_CHECKSUM_EN
    logic [31:0] s;
    s = 32'h0;
`endif
    for (int i = 0; i < img.size(); i++) begin
      send_word(img[i], i == img.size() - 1);
`ifdef IM_CHECKSUM_EN
      s = s + img[i];
`endif
      chk("loaded_words", 64'(loaded_words), 64'(i + 1));
      if (gaps && i != img.size() - 1) begin
        reload = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        reload = 1'b0;
        chk("gap_hold", 64'(loaded_words), 64'(i + 1));
      end
    end
`ifdef IM_CHECKSUM_EN
    send_word(s, 1'b0);
`endif
  endtask

  task automatic wait_run(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 3000) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("reach_run", 64'(busy), 64'd0);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #2;
    chk("rst_ready", 64'(ld_ready), 64'd0);
    chk("rst_cpu", 64'(cpu_rst), 64'd0);
    chk("rst_err", 64'(error), 64'd0);
    chk("rst_words", 64'(loaded_words), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 64'(ld_ready), 64'd1);
  endtask

  initial begin
    rd_vec_t tbl[7];
    int cyc;
    int n;

    rst = 1'b1;
    IM_Address = 16'h0;
    ld_valid = 1'b0;
    ld_data = 32'h0;
    ld_last = 1'b0;
    reload = 1'b0;
    #1;

    // ---------- reset and 3-word program, continuous valid ----------
    apply_reset();
    img = '{32'h20080005, 32'h20090003, 32'h01095020};
    tbl[0] = '{16'd0,    32'h20080005};
    tbl[1] = '{16'd1,    32'h20090003};
    tbl[2] = '{16'd2,    32'h01095020};
    tbl[3] = '{16'd3,    32'h0};
    tbl[4] = '{16'd1023, 32'h0};
    tbl[5] = '{16'd1024, 32'h0};
    tbl[6] = '{16'hFFFF, 32'h0};
    load_image(1'b0);
    chk("t1_words", 64'(loaded_words), 64'd3);
    rd(16'd0, 32'h0, "t1_nop_while_busy");
    wait_run(cyc);
    chk("t1_clear_cycles", 64'(cyc), 64'(exp_clear(3)));
    chk("t1_cpu_rst_lag", 64'(cpu_rst), 64'd0);
    @(posedge clk); #1;
    chk("t1_cpu_rst", 64'(cpu_rst), 64'd1);
    for (int i = 0; i < 7; i++) rd(tbl[i].addr, tbl[i].exp, "t1_read");

    // ---------- gaps on ld_valid, 4 words ----------
    do_reload();
    img = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    load_image(1'b1);
    wait_run(cyc);
    chk("t2_words", 64'(loaded_words), 64'd4);
    for (int a = 0; a < 6; a++) rd(16'(a), ref_word(a), "t2_read");

    // ---------- reload in RUN, 1-word image ----------
    do_reload();
    IM_Address = 16'd0;
    #1;
    chk("t5_busy", 64'(busy), 64'd1);
    chk("t5_words", 64'(loaded_words), 64'd0);
    chk("t5_nop", 64'(Instruction), 64'd0);
    @(posedge clk); #1;
    chk("t5_cpu_rst", 64'(cpu_rst), 64'd0);
    img = '{32'hAC000000};
    load_image(1'b0);
    wait_run(cyc);
    rd(16'd0, 32'hAC000000, "t5_addr0");
    rd(16'd1, 32'h0, "t5_addr1_cleared");

    // ---------- randomized images ----------
    for (int it = 0; it < 6; it++) begin
      do_reload();
      n = $urandom_range(1, 40);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back($urandom);
      load_image(1'($urandom_range(0, 1)));
      wait_run(cyc);
      chk("rnd_clear_cycles", 64'(cyc), 64'(exp_clear(n)));
      chk("rnd_words", 64'(loaded_words), 64'(n));
      chk("rnd_err", 64'(error), 64'd0);
      for (int k = 0; k < 20; k++) begin
        int a;
        a = (k < 10) ? $urandom_range(0, 48) : $urandom_range(0, 1100);
        rd(16'(a), ref_word(a), "rnd_read");
      end
    end

    // ---------- exact fill ----------
    do_reload();
    img.delete();
    for (int i = 0; i < DEPTH; i++) img.push_back(32'hA5000000 ^ 32'(i * 7 + 1));
    load_image(1'b0);
    wait_run(cyc);
    chk("t4_run_fast", 64'(cyc <= 2), 64'd1);
    chk("t4_err", 64'(error), 64'd0);
    chk("t4_words", 64'(loaded_words), 64'd1024);
    rd(16'd1023, img[1023], "t4_addr1023");
    rd(16'd1024, 32'h0, "t4_addr1024");
    for (int k = 0; k < 10; k++) begin
      int a;
      a = $urandom_range(0, DEPTH - 1);
      rd(16'(a), ref_word(a), "t4_read");
    end

    // ---------- overflow ----------
    do_reload();
    for (int i = 0; i < DEPTH; i++) send_word(32'(i + 5), 1'b0);
    chk("t3_err", 64'(error), 64'd1);
    chk("t3_ready", 64'(ld_ready), 64'd0);
    chk("t3_busy", 64'(busy), 64'd0);
    chk("t3_words", 64'(loaded_words), 64'd1024);
    rd(16'd0, 32'h0, "t3_nop");
    do_reload();
    @(posedge clk); #1;
    chk("t3_reload_ignored_err", 64'(error), 64'd1);
    chk("t3_reload_ignored_rdy", 64'(ld_ready), 64'd0);
    chk("t3_cpu_rst", 64'(cpu_rst), 64'd0);
    apply_reset();
    chk("t3_recover_err", 64'(error), 64'd0);

    // ---------- reset in the middle of a load ----------
    send_word(32'hDEAD0001, 1'b0);
    send_word(32'hDEAD0002, 1'b0);
    send_word(32'hDEAD0003, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_rst_words", 64'(loaded_words), 64'd0);
    chk("mid_rst_ready", 64'(ld_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    img = '{32'h0000BEEF, 32'h0000CAFE};
    load_image(1'b0);
    wait_run(cyc);
    for (int a = 0; a < 4; a++) rd(16'(a), ref_word(a), "mid_rst_read");

`ifdef IM_CHECKSUM_EN
    // ---------- checksum accept / reject ----------
    do_reload();
    send_word(32'd1, 1'b0);
    send_word(32'd2, 1'b0);
    send_word(32'd3, 1'b1);
    chk("cs_ready", 64'(ld_ready), 64'd1);
    chk("cs_busy", 64'(busy), 64'd1);
    send_word(32'd6, 1'b1);
    wait_run(cyc);
    chk("cs_ok_err", 64'(error), 64'd0);
    chk("cs_ok_words", 64'(loaded_words), 64'd3);
    rd(16'd3, 32'h0, "cs_not_stored");
    do_reload();
    send_word(32'd1, 1'b0);
    send_word(32'd2, 1'b0);
    send_word(32'd3, 1'b1);
    send_word(32'd7, 1'b0);
    chk("cs_bad_err", 64'(error), 64'd1);
    chk("cs_bad_ready", 64'(ld_ready), 64'd0);
    chk("cs_bad_words", 64'(loaded_words), 64'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
